// File: rtl/alu_exec_pkg.sv
// Shared definitions for the sequenced execute stage: op codes, operand/destination
// selectors and the FSM state encoding.
package alu_exec_pkg;

    localparam int OP_NOP = 0;
    localparam int OP_ADD = 1;
    localparam int OP_ADC = 2;
    localparam int OP_SUB = 3;
    localparam int OP_SBB = 4;
    localparam int OP_AND = 5;
    localparam int OP_OR  = 6;
    localparam int OP_XOR = 7;
    localparam int OP_NOT = 8;
    localparam int OP_SHL = 9;
    localparam int OP_SHR = 10;
    localparam int OP_MOV = 11;
    localparam int OP_CMP = 12;
    localparam int OP_MUL = 13;

    typedef enum logic [1:0] {
        SRC_IMM  = 2'b00,
        SRC_RF   = 2'b01,
        SRC_WMEM = 2'b10,
        SRC_BMEM = 2'b11
    } src_sel_e;

    typedef enum logic [1:0] {
        DST_RF   = 2'b00,
        DST_BMEM = 2'b01,
        DST_WMEM = 2'b10,
        DST_NONE = 2'b11
    } dst_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_MUL   = 2'b10,
        ST_EXEC  = 2'b11
    } state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Instruction handshake, RAM ports, result/flag outputs and FSM debug state of the
// execute stage. Handshake: an instruction transfers on a rising clk edge where
// in_valid and in_ready are both 1; the master holds its fields stable while
// in_valid=1 and in_ready=0.
interface alu_exec_if
    import alu_exec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IWIDTH = 8,
    parameter int AWIDTH = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [IWIDTH-1:0] op_code;
    src_sel_e          src1_sel;
    src_sel_e          src2_sel;
    logic [AWIDTH-1:0] src1;
    logic [AWIDTH-1:0] src2;
    dst_sel_e          dst_sel;
    logic [AWIDTH-1:0] dst;
    logic [AWIDTH-1:0] mem_addr_a;
    logic [AWIDTH-1:0] mem_addr_b;
    logic [WIDTH-1:0]  wmem_rdata_a;
    logic [WIDTH-1:0]  wmem_rdata_b;
    logic              bmem_rdata_a;
    logic              bmem_rdata_b;
    logic [AWIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              wmem_we;
    logic              bmem_we;
    logic [WIDTH-1:0]  result;
    logic              result_valid;
    logic              flag_c;
    logic              flag_z;
    logic              flag_b;
    logic              busy;
    state_e            dbg_state;

    modport slave (
        input  in_valid, op_code, src1_sel, src2_sel, src1, src2, dst_sel, dst,
        input  wmem_rdata_a, wmem_rdata_b, bmem_rdata_a, bmem_rdata_b,
        output in_ready, mem_addr_a, mem_addr_b, mem_waddr, mem_wdata,
        output wmem_we, bmem_we, result, result_valid, flag_c, flag_z, flag_b,
        output busy, dbg_state
    );

    modport master (
        output in_valid, op_code, src1_sel, src2_sel, src1, src2, dst_sel, dst,
        output wmem_rdata_a, wmem_rdata_b, bmem_rdata_a, bmem_rdata_b,
        input  in_ready, mem_addr_a, mem_addr_b, mem_waddr, mem_wdata,
        input  wmem_we, bmem_we, result, result_valid, flag_c, flag_z, flag_b,
        input  busy, dbg_state
    );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier (used only when MUL_EN is defined). The start cycle
// already consumes multiplier bit 0, so done_o rises in the WIDTH-th cycle.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start_i) begin
            acc_d    = b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i} << 1;
            mplier_d = b_i >> 1;
            cnt_d    = CW'(WIDTH - 1);
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            run_d    = (cnt_q != CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign busy_o    = run_q;
    assign done_o    = run_q && (cnt_q == CW'(1));
    assign product_o = acc_q;

endmodule

// File: rtl/alu_exec_unit.sv
// Sequenced execute stage: accept -> FETCH (RAM read addresses) -> EXEC (ALU, writeback,
// flags). Defining MUL_EN adds the iterative MUL op through an extra MUL state.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int IWIDTH   = 8,
    parameter int AWIDTH   = 8,
    parameter int RF_DEPTH = 16
) (
    input logic      clk,
    input logic      rst,
    alu_exec_if.slave bus
);
    localparam int RIW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;

    state_e            state_q, state_d;
    logic [IWIDTH-1:0] op_q;
    src_sel_e          s1_sel_q, s2_sel_q;
    dst_sel_e          dst_sel_q;
    logic [AWIDTH-1:0] src1_q, src2_q, dst_q;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              fc_q, fz_q, fb_q, fc_d, fz_d, fb_d;
    logic [WIDTH-1:0]  rf_q [RF_DEPTH];

    logic             accept, in_exec, is_mul, wr_ok, mul_done;
    logic             upd_c, upd_z, upd_b, alu_c, alu_b;
    logic [WIDTH-1:0] opa, opb, alu_res;
    logic [WIDTH:0]   sum;

    function automatic logic [WIDTH-1:0] operand(input src_sel_e sel, input logic [AWIDTH-1:0] imm,
                                                 input logic [WIDTH-1:0] rf_v, input logic [WIDTH-1:0] w_v,
                                                 input logic b_v);
        case (sel)
            SRC_IMM:  operand = WIDTH'(imm);
            SRC_RF:   operand = rf_v;
            SRC_WMEM: operand = w_v;
            default:  operand = WIDTH'(b_v);
        endcase
    endfunction

    assign in_exec = (state_q == ST_EXEC);
    assign opa = operand(s1_sel_q, src1_q, rf_q[src1_q[RIW-1:0]], bus.wmem_rdata_a, bus.bmem_rdata_a);
    assign opb = operand(s2_sel_q, src2_q, rf_q[src2_q[RIW-1:0]], bus.wmem_rdata_b, bus.bmem_rdata_b);

`ifdef MUL_EN
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_busy;

    assign is_mul = (op_q == IWIDTH'(OP_MUL));

    // Operands come straight from the operand mux: RAM data is valid in the first MUL cycle.
    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   ((state_q == ST_MUL) && !mul_busy),
        .a_i       (opa),
        .b_i       (opb),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
`endif

    assign bus.in_ready = (state_q == ST_IDLE) || (in_exec && !is_mul);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_FETCH;
            ST_FETCH: state_d = is_mul ? ST_MUL : ST_EXEC;
            ST_MUL:   if (mul_done) state_d = ST_EXEC;
            ST_EXEC:  state_d = accept ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = fc_q;
        alu_b   = fb_q;
        upd_c   = 1'b0;
        upd_z   = 1'b0;
        upd_b   = 1'b0;
        wr_ok   = 1'b1;
        case (op_q)
            IWIDTH'(OP_ADD): begin sum = {1'b0, opa} + {1'b0, opb}; upd_c = 1'b1; upd_z = 1'b1; end
            IWIDTH'(OP_ADC): begin sum = {1'b0, opa} + {1'b0, opb} + (WIDTH+1)'(fc_q); upd_c = 1'b1; upd_z = 1'b1; end
            IWIDTH'(OP_SUB): begin sum = {1'b0, opa} - {1'b0, opb}; upd_b = 1'b1; upd_z = 1'b1; end
            IWIDTH'(OP_SBB): begin sum = {1'b0, opa} - {1'b0, opb} - (WIDTH+1)'(fb_q); upd_b = 1'b1; upd_z = 1'b1; end
            IWIDTH'(OP_CMP): begin sum = {1'b0, opa} - {1'b0, opb}; upd_b = 1'b1; upd_z = 1'b1; wr_ok = 1'b0; end
            IWIDTH'(OP_AND): begin sum = {1'b0, opa & opb}; upd_z = 1'b1; end
            IWIDTH'(OP_OR):  begin sum = {1'b0, opa | opb}; upd_z = 1'b1; end
            IWIDTH'(OP_XOR): begin sum = {1'b0, opa ^ opb}; upd_z = 1'b1; end
            IWIDTH'(OP_NOT): begin sum = {1'b0, ~opa}; upd_z = 1'b1; end
            IWIDTH'(OP_SHL): begin sum = {opa[WIDTH-1], opa << 1}; upd_c = 1'b1; upd_z = 1'b1; end
            IWIDTH'(OP_SHR): begin sum = {opa[0], opa >> 1}; upd_c = 1'b1; upd_z = 1'b1; end
            IWIDTH'(OP_MOV): begin sum = {1'b0, opa}; end
`ifdef MUL_EN
            IWIDTH'(OP_MUL): begin sum = {|mul_prod[2*WIDTH-1:WIDTH], mul_prod[WIDTH-1:0]}; upd_c = 1'b1; upd_z = 1'b1; end
`endif
            default:         wr_ok = 1'b0;
        endcase
        // Top bit of sum is carry, borrow or shifted-out bit depending on the op.
        alu_res = sum[WIDTH-1:0];
        if (upd_c) alu_c = sum[WIDTH];
        if (upd_b) alu_b = sum[WIDTH];
    end

    assign result_d = in_exec ? alu_res : result_q;
    assign fc_d     = (in_exec && upd_c) ? alu_c : fc_q;
    assign fb_d     = (in_exec && upd_b) ? alu_b : fb_q;
    assign fz_d     = (in_exec && upd_z) ? (alu_res == '0) : fz_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            s1_sel_q  <= SRC_IMM;
            s2_sel_q  <= SRC_IMM;
            dst_sel_q <= DST_NONE;
            src1_q    <= '0;
            src2_q    <= '0;
            dst_q     <= '0;
            result_q  <= '0;
            fc_q      <= 1'b0;
            fz_q      <= 1'b0;
            fb_q      <= 1'b0;
            for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
            fb_q     <= fb_d;
            if (accept) begin
                op_q      <= bus.op_code;
                s1_sel_q  <= bus.src1_sel;
                s2_sel_q  <= bus.src2_sel;
                dst_sel_q <= bus.dst_sel;
                src1_q    <= bus.src1;
                src2_q    <= bus.src2;
                dst_q     <= bus.dst;
            end
            if (in_exec && wr_ok && dst_sel_q == DST_RF) rf_q[dst_q[RIW-1:0]] <= alu_res;
        end
    end

    assign bus.mem_addr_a   = src1_q;
    assign bus.mem_addr_b   = src2_q;
    assign bus.mem_waddr    = dst_q;
    assign bus.mem_wdata    = alu_res;
    assign bus.wmem_we      = !rst && in_exec && wr_ok && (dst_sel_q == DST_WMEM);
    assign bus.bmem_we      = !rst && in_exec && wr_ok && (dst_sel_q == DST_BMEM);
    assign bus.result       = result_q;
    assign bus.result_valid = !rst && in_exec;
    assign bus.flag_c       = fc_q;
    assign bus.flag_z       = fz_q;
    assign bus.flag_b       = fb_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: driver tasks push expected responses, a monitor
// compares them when result_valid pulses. Define MUL_EN to cover the multiplier.
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_if bus ();

    alu_exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  res;
        logic [2:0]  flags;  // {c, z, b}
        logic [1:0]  we;     // {wmem_we, bmem_we}
        logic [7:0]  waddr;
        logic [7:0]  wdata;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];
    int checks  = 0;
    int fails   = 0;
    int pending = 0;
    int cyc     = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Word/bit RAM model with 1-cycle synchronous reads.
    logic [7:0] wram [256];
    logic       bram [256];
    always @(posedge clk) begin
        bus.wmem_rdata_a <= wram[bus.mem_addr_a];
        bus.wmem_rdata_b <= wram[bus.mem_addr_b];
        bus.bmem_rdata_a <= bram[bus.mem_addr_a];
        bus.bmem_rdata_b <= bram[bus.mem_addr_b];
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                wram[i] <= 8'h00;
                bram[i] <= (i == 7);
            end
        end else begin
            if (bus.wmem_we) wram[bus.mem_waddr] <= bus.mem_wdata;
            if (bus.bmem_we) bram[bus.mem_waddr] <= bus.mem_wdata[0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] res, input logic [2:0] flags, input logic [1:0] we,
                                input logic [7:0] waddr, input logic [7:0] wdata);
        exp_t e;
        e.cyc   = '0;
        e.res   = res;
        e.flags = flags;
        e.we    = we;
        e.waddr = waddr;
        e.wdata = wdata;
        return e;
    endfunction

    // Monitor: write strobes are checked in the result_valid cycle, result/flags one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.result_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_valid: got result_valid=1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = exp_t'(exp_q.pop_front());
                        check("valid_cycle", cyc, e.cyc);
                        check("wmem_we", bus.wmem_we, e.we[1]);
                        check("bmem_we", bus.bmem_we, e.we[0]);
                        if (e.we != 2'b00) begin
                            check("mem_waddr", bus.mem_waddr, e.waddr);
                            check("mem_wdata", bus.mem_wdata, e.wdata);
                        end
                        @(negedge clk);
                        check("result", bus.result, e.res);
                        check("flags_czb", {bus.flag_c, bus.flag_z, bus.flag_b}, e.flags);
                        pending--;
                    end
                end else if (bus.wmem_we || bus.bmem_we) begin
                    checks++;
                    fails++;
                    $display("FAIL spurious_we: got we=%b%b expected 00 (cycle %0d)", bus.wmem_we, bus.bmem_we, cyc);
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting edge with in_valid still high.
    task automatic send(input int op, input src_sel_e s1s, input logic [7:0] s1, input src_sel_e s2s,
                        input logic [7:0] s2, input dst_sel_e ds, input logic [7:0] d, input exp_t e,
                        input int lat, input bit expect_it, output int acc);
        bus.in_valid = 1'b1;
        bus.op_code  = 8'(op);
        bus.src1_sel = s1s;
        bus.src1     = s1;
        bus.src2_sel = s2s;
        bus.src2     = s2;
        bus.dst_sel  = ds;
        bus.dst      = d;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.in_ready) begin
                acc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 40 cycles (op %0d)", op);
            bus.in_valid = 1'b0;
        end else begin
            if (expect_it) begin
                e.cyc = 32'(acc + lat);
                exp_q.push_back(e);
                pending++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 60; k++) begin
            if (pending == 0) break;
            @(posedge clk);
            #1;
        end
        if (k == 60) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", pending);
            exp_q.delete();
            pending = 0;
        end
    endtask

    task automatic run(input int op, input src_sel_e s1s, input logic [7:0] s1, input src_sel_e s2s,
                       input logic [7:0] s2, input dst_sel_e ds, input logic [7:0] d, input exp_t e,
                       input int lat = 2);
        int acc;
        send(op, s1s, s1, s2s, s2, ds, d, e, lat, 1'b1, acc);
        bus.in_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        int acc_a, acc_b, acc_x;
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", checks - fails - 1, checks + 1);
        $finish;
    end

    initial begin
        int acc_a, acc_b, acc_x;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op_code  = '0;
        bus.src1_sel = SRC_IMM;
        bus.src2_sel = SRC_IMM;
        bus.src1     = '0;
        bus.src2     = '0;
        bus.dst_sel  = DST_NONE;
        bus.dst      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_result", bus.result, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_flags", {bus.flag_c, bus.flag_z, bus.flag_b}, 3'b000);
        mon_en = 1'b1;

        run(OP_ADD, SRC_IMM, 8'h7F, SRC_IMM, 8'h01, DST_RF,   8'h03, mk(8'h80, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_MOV, SRC_RF,  8'h03, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h80, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_ADD, SRC_IMM, 8'hFF, SRC_IMM, 8'h01, DST_NONE, 8'h00, mk(8'h00, 3'b110, 2'b00, 8'h00, 8'h00));
        run(OP_ADC, SRC_IMM, 8'h00, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h01, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_SUB, SRC_IMM, 8'h03, SRC_IMM, 8'h05, DST_WMEM, 8'h20, mk(8'hFE, 3'b001, 2'b10, 8'h20, 8'hFE));
        run(OP_SBB, SRC_IMM, 8'h10, SRC_IMM, 8'h01, DST_NONE, 8'h00, mk(8'h0E, 3'b000, 2'b00, 8'h00, 8'h00));

        // Back-to-back: second instruction reads the RF entry written by the first.
        send(OP_ADD, SRC_IMM, 8'h05, SRC_IMM, 8'h03, DST_RF, 8'h05, mk(8'h08, 3'b000, 2'b00, 8'h00, 8'h00), 2, 1'b1, acc_a);
        send(OP_ADD, SRC_RF,  8'h05, SRC_IMM, 8'h01, DST_RF, 8'h06, mk(8'h09, 3'b000, 2'b00, 8'h00, 8'h00), 2, 1'b1, acc_b);
        bus.in_valid = 1'b0;
        check("b2b_accept_cycle", acc_b, acc_a + 2);
        wait_done();
        run(OP_MOV, SRC_RF,   8'h06, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h09, 3'b000, 2'b00, 8'h00, 8'h00));

        run(OP_OR,  SRC_BMEM, 8'h07, SRC_IMM, 8'h00, DST_BMEM, 8'h05, mk(8'h01, 3'b000, 2'b01, 8'h05, 8'h01));
        run(OP_OR,  SRC_BMEM, 8'h05, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h01, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_AND, SRC_IMM,  8'hFF, SRC_IMM, 8'h0F, DST_WMEM, 8'h21, mk(8'h0F, 3'b000, 2'b10, 8'h21, 8'h0F));
        run(OP_SUB, SRC_WMEM, 8'h20, SRC_IMM, 8'h0E, DST_NONE, 8'h00, mk(8'hF0, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_XOR, SRC_IMM,  8'hAA, SRC_IMM, 8'hFF, DST_NONE, 8'h00, mk(8'h55, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_NOT, SRC_IMM,  8'hF0, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h0F, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_SHL, SRC_IMM,  8'h81, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h02, 3'b100, 2'b00, 8'h00, 8'h00));
        run(OP_CMP, SRC_IMM,  8'h04, SRC_IMM, 8'h05, DST_WMEM, 8'h22, mk(8'hFF, 3'b101, 2'b00, 8'h00, 8'h00));
        run(OP_CMP, SRC_IMM,  8'h05, SRC_IMM, 8'h05, DST_RF,   8'h00, mk(8'h00, 3'b110, 2'b00, 8'h00, 8'h00));
        run(OP_NOP, SRC_IMM,  8'h12, SRC_IMM, 8'h34, DST_RF,   8'h00, mk(8'h00, 3'b110, 2'b00, 8'h00, 8'h00));
        // RF index wraps: 0x13 lands on entry 3.
        run(OP_ADD, SRC_IMM,  8'h33, SRC_IMM, 8'h00, DST_RF,   8'h13, mk(8'h33, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_MOV, SRC_RF,   8'h03, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h33, 3'b000, 2'b00, 8'h00, 8'h00));
        run(OP_SHR, SRC_IMM,  8'h01, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h00, 3'b110, 2'b00, 8'h00, 8'h00));
        run(15,     SRC_IMM,  8'h77, SRC_IMM, 8'h01, DST_WMEM, 8'h30, mk(8'h00, 3'b110, 2'b00, 8'h00, 8'h00));
`ifdef MUL_EN
        run(OP_MUL, SRC_IMM,  8'h0F, SRC_IMM, 8'h11, DST_WMEM, 8'h31, mk(8'hFF, 3'b000, 2'b10, 8'h31, 8'hFF), 10);
        run(OP_MUL, SRC_IMM,  8'h10, SRC_IMM, 8'h10, DST_NONE, 8'h00, mk(8'h00, 3'b110, 2'b00, 8'h00, 8'h00), 10);
`else
        run(OP_MUL, SRC_IMM,  8'h0F, SRC_IMM, 8'h11, DST_WMEM, 8'h31, mk(8'h00, 3'b110, 2'b00, 8'h00, 8'h00));
`endif

        // Abort in FETCH: no write, no result_valid, everything back to reset values.
        send(OP_ADD, SRC_IMM, 8'hFF, SRC_IMM, 8'h01, DST_WMEM, 8'h40, mk(8'h00, 3'b000, 2'b00, 8'h00, 8'h00), 2, 1'b0, acc_x);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_flags", {bus.flag_c, bus.flag_z, bus.flag_b}, 3'b000);
        check("abort_result", bus.result, 0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_write", wram[8'h40], 8'h00);
        run(OP_MOV, SRC_RF, 8'h03, SRC_IMM, 8'h00, DST_NONE, 8'h00, mk(8'h00, 3'b000, 2'b00, 8'h00, 8'h00));

        wait_done();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
